mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester memory arbiter. A CPU (multicycle controller) and a
//   loader/DMA engine share one memory port. Ties alternate between the
//   two requesters. Each access waits for mem_ready for at most TIMEOUT
//   busy cycles and is then reported to the requester with an error flag.
//
// Parameters
//   ADDR_W   memory address width
//   DATA_W   memory data width
//   TIMEOUT  maximum number of BUSY cycles to wait for mem_ready (2..255)
//
// Ports
//   clk, rst                         rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request, level-held until cpu_ack
//   cpu_ack, cpu_err                 one-cycle completion pulse, timeout flag
//   dma_req/we/addr/wdata            DMA request, level-held until dma_ack
//   dma_ack, dma_err                 one-cycle completion pulse, timeout flag
//   rdata                            read data, valid while either ack is high
//   mem_read, mem_write              memory strobes, high for the whole access
//   mem_addr, mem_wdata              memory address / write data (latched copies)
//   mem_rdata, mem_ready             memory read data and completion
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DMA, ACK} state_t;

  // Last busy cycle index; reaching it without mem_ready ends the access.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic              lastGntDma_q;
  logic              gntDma_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        busyCnt_q;
  logic              err_q;
  logic              cpuAck_q;
  logic              dmaAck_q;
  logic              memRead_q;
  logic              memWrite_q;

  logic              grantDma_d;
  logic              selWe_d;
  logic [ADDR_W-1:0] selAddr_d;
  logic [DATA_W-1:0] selWdata_d;

  // Grant selection used only while IDLE. DMA wins when it is the only
  // requester, or on a tie when the CPU was the one served last. The
  // selected request fields feed registers only, never the mem_* ports.
  always_comb begin
    grantDma_d = dma_req & (~cpu_req | ~lastGntDma_q);
    selWe_d    = grantDma_d ? dma_we    : cpu_we;
    selAddr_d  = grantDma_d ? dma_addr  : cpu_addr;
    selWdata_d = grantDma_d ? dma_wdata : cpu_wdata;
  end

  // Arbiter FSM with registered strobes and acks. Strobes rise on the
  // grant edge and fall on the edge leaving BUSY; the ack of the granted
  // requester is raised on that same edge so it covers exactly the ACK
  // cycle. A reset during BUSY simply drops the access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lastGntDma_q <= 1'b1;
      gntDma_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      busyCnt_q    <= 8'd0;
      err_q        <= 1'b0;
      cpuAck_q     <= 1'b0;
      dmaAck_q     <= 1'b0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
    end else begin
      cpuAck_q <= 1'b0;
      dmaAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            gntDma_q   <= grantDma_d;
            we_q       <= selWe_d;
            addr_q     <= selAddr_d;
            wdata_q    <= selWdata_d;
            busyCnt_q  <= 8'd0;
            memRead_q  <= ~selWe_d;
            memWrite_q <= selWe_d;
            state_q    <= grantDma_d ? BUSY_DMA : BUSY_CPU;
          end
        end
        BUSY_CPU, BUSY_DMA: begin
          // mem_ready takes priority over the timeout on the last cycle.
          if (mem_ready || (busyCnt_q == CntLast)) begin
            if (mem_ready) begin
              if (!we_q) begin
                rdata_q <= mem_rdata;
              end
              err_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            cpuAck_q   <= ~gntDma_q;
            dmaAck_q   <= gntDma_q;
            state_q    <= ACK;
          end else begin
            busyCnt_q <= busyCnt_q + 8'd1;
          end
        end
        ACK: begin
          lastGntDma_q <= gntDma_q;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = cpuAck_q;
  assign dma_ack   = dmaAck_q;
  assign cpu_err   = cpuAck_q & err_q;
  assign dma_err   = dmaAck_q & err_q;
  assign rdata     = rdata_q;
  assign mem_read  = memRead_q;
  assign mem_write = memWrite_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Testbench for mem_arbiter. A memory responder raises mem_ready after a
//   programmable number of strobe cycles (0 = never) and returns data from
//   a fixed address hash. Directed vectors come from a table; a random
//   phase predicts each transaction from the arbitration and timeout rules.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack, cpu_err;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_ack, dma_err;
  logic [DW-1:0] rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int            total = 0;
  int            bad = 0;
  int            memDelay = 1;
  int            strobeCnt = 0;
  logic [DW-1:0] lastAckRdata = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory responder: counts strobe cycles and answers on cycle memDelay.
  // Non-ready cycles carry junk read data so early sampling shows up.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      strobeCnt = strobeCnt + 1;
      mem_ready = (memDelay != 0) && (strobeCnt == memDelay);
      mem_rdata = mem_ready ? memData(mem_addr) : (32'hBAD0_0000 | strobeCnt);
    end else begin
      strobeCnt = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0BAD_F00D;
    end
  end

  typedef struct {
    logic          cpuReq;
    logic          cpuWe;
    logic [AW-1:0] cpuAddr;
    logic [DW-1:0] cpuWdata;
    logic          dmaReq;
    logic          dmaWe;
    logic [AW-1:0] dmaAddr;
    logic [DW-1:0] dmaWdata;
    int            delay;
    logic          expDma;
    int            expBusy;
    logic          expErr;
    logic [DW-1:0] expRdata;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetState",
                {cpu_ack, cpu_err, dma_ack, dma_err, mem_read, mem_write, rdata},
                {6'b0, 32'h0});
    lastAckRdata = '0;
  endtask

  // Runs one transaction from an IDLE cycle and checks it against v. The
  // granted requester's inputs are scrambled during BUSY; the memory side
  // must keep the values captured at grant time.
  task automatic applyStimulus(input vec_t v, input string name);
    int            busy;
    int            ackAt;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWdata;
    logic          eWe;
    eAddr  = v.expDma ? v.dmaAddr  : v.cpuAddr;
    eWdata = v.expDma ? v.dmaWdata : v.cpuWdata;
    eWe    = v.expDma ? v.dmaWe    : v.cpuWe;
    @(posedge clk); #1;
    cpu_req = v.cpuReq; cpu_we = v.cpuWe; cpu_addr = v.cpuAddr; cpu_wdata = v.cpuWdata;
    dma_req = v.dmaReq; dma_we = v.dmaWe; dma_addr = v.dmaAddr; dma_wdata = v.dmaWdata;
    memDelay = v.delay;
    busy  = 0;
    ackAt = -1;
    for (int n = 0; (n <= TO + 6) && (ackAt < 0); n++) begin
      @(negedge clk);
      if (n == 0) begin
        checkOutput({name, ".idle"}, {cpu_ack, dma_ack, mem_read, mem_write, rdata},
                    {4'b0, lastAckRdata});
      end else if (mem_read || mem_write) begin
        busy++;
        checkOutput({name, ".strobe"}, {mem_read, mem_write}, {~eWe, eWe});
        checkOutput({name, ".addr"}, mem_addr, eAddr);
        if (eWe) checkOutput({name, ".wdata"}, mem_wdata, eWdata);
        if (v.expDma) begin
          dma_addr = $urandom; dma_wdata = $urandom; dma_we = 1'($urandom_range(0, 1));
        end else begin
          cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom_range(0, 1));
        end
      end
      if (cpu_ack || dma_ack) begin
        ackAt = n;
        checkOutput({name, ".ackSel"}, {cpu_ack, dma_ack}, {~v.expDma, v.expDma});
        checkOutput({name, ".err"}, {cpu_err, dma_err},
                    v.expDma ? {1'b0, v.expErr} : {v.expErr, 1'b0});
        checkOutput({name, ".rdata"}, rdata, v.expRdata);
      end
    end
    checkOutput({name, ".latency"}, 64'(ackAt), 64'(v.expBusy + 1));
    checkOutput({name, ".busyCycles"}, 64'(busy), 64'(v.expBusy));
    if (v.expDma) dma_req = 1'b0;
    else          cpu_req = 1'b0;
    lastAckRdata = v.expRdata;
  endtask

  vec_t vecs[9];
  vec_t v;
  int   ackSeen;

  // Random-phase model state: pending requests, their parameters, who was
  // served last and the read data the block should be holding.
  logic          cpuPend, dmaPend, lastDma, winDma, okRdy;
  logic          cWe, dWe;
  logic [AW-1:0] cAddr, dAddr;
  logic [DW-1:0] cWdata, dWdata, curRdata;
  int            dly;

  initial begin
    //          cReq cWe  cAddr     cWdata        dReq dWe  dAddr     dWdata     dly expDma busy err  rdata
    vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 1'b0, 32'h80, 32'h0,     1,  1'b0, 1,  1'b0, 32'hA5A5_0040};
    vecs[1] = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b1, 1'b0, 32'h80, 32'h0,     2,  1'b1, 2,  1'b0, 32'hA5A5_0080};
    vecs[2] = '{1'b1, 1'b0, 32'h48, 32'h0,        1'b1, 1'b0, 32'h84, 32'h0,     1,  1'b0, 1,  1'b0, 32'hA5A5_0048};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h20, 32'h1234,  4,  1'b1, 4,  1'b0, 32'hA5A5_0048};
    vecs[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,     1,  1'b0, 1,  1'b0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h50, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,     0,  1'b0, TO, 1'b1, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h60, 32'h0,     TO, 1'b1, TO, 1'b0, 32'hA5A5_0060};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h64, 32'h0,     TO + 1, 1'b1, TO, 1'b1, 32'hA5A5_0060};
    vecs[8] = '{1'b1, 1'b1, 32'h70, 32'h5555AAAA, 1'b0, 1'b0, 32'h0,  32'h0,     3,  1'b0, 3,  1'b0, 32'hA5A5_0060};

    $display("[TB] directed table");
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset in the second BUSY cycle: access dropped, no ack, state cleared.
    $display("[TB] reset during BUSY");
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h90; dma_req = 1'b0;
    memDelay = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midBusy.strobe", {mem_read, mem_write}, 2'b10);
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    ackSeen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0)
        checkOutput("midBusy.afterReset", {mem_read, mem_write, cpu_ack, dma_ack, rdata},
                    {4'b0, 32'h0});
      if (cpu_ack || dma_ack) ackSeen++;
    end
    checkOutput("midBusy.noAck", 64'(ackSeen), 64'd0);
    lastAckRdata = '0;
    // The last grant before the reset went to the CPU; after reset the
    // tie must go to the CPU again, then the still-pending DMA request.
    v = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1, 1'b0, 1, 1'b0, 32'hDEAD_BEEF};
    applyStimulus(v, "postReset0");
    v = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 2, 1'b1, 2, 1'b0, 32'hA5A5_0030};
    applyStimulus(v, "postReset1");

    // Randomised transactions predicted from the arbitration rules.
    $display("[TB] random phase");
    doReset();
    cpuPend = 1'b0; dmaPend = 1'b0; lastDma = 1'b1; curRdata = '0;
    cWe = 1'b0; dWe = 1'b0; cAddr = '0; dAddr = '0; cWdata = '0; dWdata = '0;
    for (int it = 0; it < 60; it++) begin
      if (!cpuPend && ($urandom_range(0, 1) == 1)) begin
        cpuPend = 1'b1; cWe = 1'($urandom_range(0, 1));
        cAddr = 32'($urandom_range(0, 63)) << 2; cWdata = $urandom;
      end
      if (!dmaPend && ($urandom_range(0, 1) == 1)) begin
        dmaPend = 1'b1; dWe = 1'($urandom_range(0, 1));
        dAddr = 32'($urandom_range(0, 63)) << 2; dWdata = $urandom;
      end
      if (!cpuPend && !dmaPend) begin
        cpuPend = 1'b1; cWe = 1'b0; cAddr = 32'($urandom_range(0, 63)) << 2; cWdata = $urandom;
      end
      dly = $urandom_range(0, 20);
      if (cpuPend && dmaPend) winDma = ~lastDma;
      else                    winDma = dmaPend;
      okRdy = (dly >= 1) && (dly <= TO);
      v.cpuReq = cpuPend; v.cpuWe = cWe; v.cpuAddr = cAddr; v.cpuWdata = cWdata;
      v.dmaReq = dmaPend; v.dmaWe = dWe; v.dmaAddr = dAddr; v.dmaWdata = dWdata;
      v.delay   = dly;
      v.expDma  = winDma;
      v.expBusy = okRdy ? dly : TO;
      v.expErr  = ~okRdy;
      if (okRdy && !(winDma ? dWe : cWe)) curRdata = memData(winDma ? dAddr : cAddr);
      v.expRdata = curRdata;
      applyStimulus(v, $sformatf("rnd%0d", it));
      lastDma = winDma;
      if (winDma) dmaPend = 1'b0;
      else        cpuPend = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
